// File: rtl/dmp_stream_engine.sv
// dmp_stream_engine: barrier-syncs all gather threads, then streams rank beats (concat or reduce).
// Define DMP_SATURATE_EN to make reduce-mode sums saturate instead of wrapping.
module dmp_stream_engine #(
  parameter int NUM_HW_THREADS = 2,
  parameter int NODES_IN_GRAPH = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int LANES          = 2,
  parameter int ITER_WIDTH     = 16
) (
  input  logic                                                        clock,
  input  logic                                                        reset_n,
  input  logic [NUM_HW_THREADS-1:0][NODES_IN_GRAPH-1:0][DATA_WIDTH-1:0] page_rank_gather,
  input  logic [NUM_HW_THREADS-1:0]                                   done,
  input  logic                                                        mode,
  input  logic                                                        nextIteration,
  output logic [LANES-1:0][DATA_WIDTH-1:0]                            out_data,
  output logic                                                        out_valid,
  input  logic                                                        out_ready,
  output logic                                                        out_last,
  output logic                                                        stream_start,
  output logic                                                        stream_done,
  output logic                                                        busy,
  output logic [ITER_WIDTH-1:0]                                       iteration_count
);

  localparam int GROUPS = (NODES_IN_GRAPH + LANES - 1) / LANES;
  localparam int TW     = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [TW-1:0] LAST_THREAD = TW'(NUM_HW_THREADS - 1);
  localparam logic [GW-1:0] LAST_GROUP  = GW'(GROUPS - 1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_STREAM,
    ST_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_HW_THREADS-1:0] sync_q, sync_d;
  logic [TW-1:0]             thread_q, thread_d;
  logic [GW-1:0]             group_q, group_d;
  logic                      mode_q, mode_d;
  logic [ITER_WIDTH-1:0]     iter_q, iter_d;
  logic                      start_q, start_d;
  logic                      sdone_q, sdone_d;
  logic                      last_beat;

  function automatic logic [DATA_WIDTH-1:0] rank_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
`ifdef DMP_SATURATE_EN
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_WIDTH] ? '1 : s[DATA_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  // In reduce mode the thread counter never advances, so the group alone ends the stream.
  assign last_beat = (state_q == ST_STREAM) && (group_q == LAST_GROUP) &&
                     (mode_q || (thread_q == LAST_THREAD));

  always_comb begin
    // NOTE: every variable gets its default first so no path can infer a latch.
    state_d  = state_q;
    sync_d   = sync_q;
    thread_d = thread_q;
    group_d  = group_q;
    mode_d   = mode_q;
    iter_d   = iter_q;
    start_d  = 1'b0;
    sdone_d  = 1'b0;
    unique case (state_q)
      ST_SYNC: begin
        sync_d = sync_q | done;
        if (&sync_d) begin
          state_d  = ST_STREAM;
          mode_d   = mode;
          thread_d = '0;
          group_d  = '0;
          start_d  = 1'b1;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (last_beat) begin
            state_d = ST_DONE;
            sdone_d = 1'b1;
            iter_d  = iter_q + 1'b1;
          end else if (group_q == LAST_GROUP) begin
            group_d  = '0;
            thread_d = thread_q + 1'b1;
          end else begin
            group_d = group_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (nextIteration) begin
          sync_d  = '0;
          state_d = ST_SYNC;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin : beat_mux
    logic [DATA_WIDTH-1:0] pick;
    logic [DATA_WIDTH-1:0] acc;
    pick     = '0;
    acc      = '0;
    out_data = '0;
    for (int l = 0; l < LANES; l++) begin
      pick = '0;
      acc  = '0;
      // Lanes past the end of the node vector never match a node and stay zero.
      for (int n = 0; n < NODES_IN_GRAPH; n++) begin
        if (n == int'(group_q) * LANES + l) begin
          for (int t = 0; t < NUM_HW_THREADS; t++) begin
            if (t == int'(thread_q)) pick = page_rank_gather[t][n];
            acc = rank_add(acc, page_rank_gather[t][n]);
          end
        end
      end
      if (state_q == ST_STREAM) out_data[l] = mode_q ? acc : pick;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q  <= ST_SYNC;
      sync_q   <= '0;
      thread_q <= '0;
      group_q  <= '0;
      mode_q   <= 1'b0;
      iter_q   <= '0;
      start_q  <= 1'b0;
      sdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      thread_q <= thread_d;
      group_q  <= group_d;
      mode_q   <= mode_d;
      iter_q   <= iter_d;
      start_q  <= start_d;
      sdone_q  <= sdone_d;
    end
  end

  assign out_valid       = (state_q == ST_STREAM);
  assign busy            = (state_q == ST_STREAM);
  assign out_last        = last_beat;
  assign stream_start    = start_q;
  assign stream_done     = sdone_q;
  assign iteration_count = iter_q;

endmodule

// File: doc/dmp_stream_engine.md
Name: dmp_stream_engine

Overview:
- Parametrised successor to the DMP serial stage in the PageRank pipeline.
- Sits between the per-thread gather units and the apply/writeback stage.
- Barrier-syncs all gather threads, then streams rank values downstream with valid/ready backpressure, LANES nodes per beat.
- Two modes: per-thread concatenation, or cross-thread reduction (sum per node).

Parameters:
NUM_HW_THREADS, 2, number of gather threads (>=1)
NODES_IN_GRAPH, 4, nodes per thread vector (>=1)
DATA_WIDTH, 64, bits per rank value
LANES, 2, rank values per output beat (1..NODES_IN_GRAPH)
ITER_WIDTH, 16, width of iteration counter

Ports:
clock  in  1  system clock
reset_n  in  1  reset; synchronous and active-low
page_rank_gather  in  [NUM_HW_THREADS][NODES_IN_GRAPH] x DATA_WIDTH  gather results; held stable by threads from done until stream_done
done  in  [NUM_HW_THREADS] x 1  per-thread gather-complete level/pulse
mode  in  1  0=concat (thread-major), 1=reduce (sum across threads); sampled at barrier release
nextIteration  in  1  re-arm request; honoured only in DONE
out_data  out  [LANES] x DATA_WIDTH  beat payload
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_last  out  1  high with final beat of iteration
stream_start  out  1  one-cycle pulse on first cycle of STREAM
stream_done  out  1  one-cycle pulse after final beat accepted
busy  out  1  high in STREAM
iteration_count  out  ITER_WIDTH  completed iterations, wraps at 2^ITER_WIDTH

Behaviour:
- Reset (reset_n=0 at posedge): state=SYNC; sync bits, beat counters, mode latch and iteration_count = 0; all outputs 0. Reset mid-stream aborts the stream with no stream_done.
- States: SYNC, STREAM, DONE.
- SYNC:
  - sync[t] set on any edge where done[t]=1; sticky.
  - On the edge where all sync bits become 1 (including all arriving together): latch mode, clear counters, go to STREAM.
  - First beat is valid the cycle after that edge: one-cycle done-to-valid latency.
- STREAM, beat sequencing:
  - G = ceil(NODES_IN_GRAPH/LANES).
  - Mode 0: beats ordered thread t=0..T-1 outer, group g=0..G-1 inner; T*G beats. Lane l = page_rank_gather[t][g*LANES+l].
  - Mode 1: G beats. Lane l = sum over t of page_rank_gather[t][g*LANES+l], computed modulo 2^DATA_WIDTH, unsigned.
  - Lanes with index >= NODES_IN_GRAPH output 0.
- STREAM, handshake:
  - Beat transfers when out_valid and out_ready are both 1.
  - While out_ready=0, out_data, out_valid and out_last stay stable.
  - out_valid is held high continuously through STREAM; there are no bubbles.
  - out_last=1 only on the final beat.
- STREAM exit:
  - When the final beat transfers: go to DONE, pulse stream_done, increment iteration_count on the same edge.
  - done inputs are ignored in STREAM and DONE.
- DONE:
  - out_valid=0.
  - nextIteration=1 clears sync bits and goes to SYNC.
  - nextIteration in SYNC or STREAM has no effect.
- stream_start is high exactly in the first STREAM cycle, even if that beat stalls.
- Mode changes mid-stream have no effect until the next barrier release.

Optional Feature:
DMP_SATURATE_EN
- Defined: reduce-mode sums saturate at 2^DATA_WIDTH-1 (all ones) on unsigned overflow.
- Undefined: sums wrap modulo 2^DATA_WIDTH.
- Concat mode is unaffected either way.

Test Plan:
- Concat, T=2, N=4, L=2, W=64, gather[0]={1,2,3,4}, gather[1]={5,6,7,8}, done[0]=1 then done[1]=1 two cycles later, out_ready=1:
  - 4 beats {1,2},{3,4},{5,6},{7,8}, out_last on beat 4.
  - stream_start on first valid cycle, stream_done one cycle after beat 4.
  - iteration_count=1.
- Reduce, same data, mode=1: 2 beats {6,8},{10,12}, out_last on beat 2.
- Backpressure: out_ready toggles 0,0,1 per beat -> payload stable across stalls, no beat lost or duplicated, 4 beats total.
- Overflow, reduce mode, gather[0][0]=gather[1][0]=2^63+1:
  - Without macro: lane0=2.
  - With DMP_SATURATE_EN: lane0=2^64-1.
- Odd size N=3, L=2, concat: lane1 of beats 2 and 4 = 0; 4 beats total.
- Re-arm and reset:
  - nextIteration during STREAM is ignored; in DONE -> SYNC and a second iteration streams, iteration_count=2.
  - reset_n=0 mid-stream -> out_valid=0 next cycle, state SYNC, iteration_count=0, no stream_done.
